// File: rtl/pixel_port_arbiter_pkg.sv
// Shared screen geometry, pixel field widths and arbiter FSM encoding for the pixel port arbiter.
package pixel_port_arbiter_pkg;

    localparam int unsigned SCREEN_W = 320;
    localparam int unsigned SCREEN_H = 240;
    localparam int unsigned X_W      = 9;
    localparam int unsigned Y_W      = 8;
    localparam int unsigned C_W      = 3;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StGrant   = 2'd1,
        StRelease = 2'd2
    } arb_state_e;

endpackage

// File: rtl/pixel_port_arbiter_picker.sv
// Round-robin priority picker: one-hot winner among req, searching upward from ptr with wrap.
module rr_priority_picker #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned PTR_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  winner,
    output logic             any
);

    int unsigned idx;

    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            idx = (32'(ptr) + i) % NREQ;
            if (!any && req[idx]) begin
                winner[idx] = 1'b1;
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pixel_port_arbiter.sv
// Arbitrates pixel-write bursts from NREQ requesters onto a single registered VGA plot port.
module pixel_port_arbiter
    import pixel_port_arbiter_pkg::*;
#(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*X_W-1:0]   req_x,
    input  logic [NREQ*Y_W-1:0]   req_y,
    input  logic [NREQ*C_W-1:0]   req_colour,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       gnt,
    output logic [X_W-1:0]        vga_x,
    output logic [Y_W-1:0]        vga_y,
    output logic [C_W-1:0]        vga_colour,
    output logic                  vga_plot,
    output logic                  busy
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    arb_state_e       state_q, state_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [X_W-1:0]   vga_x_q, vga_x_d;
    logic [Y_W-1:0]   vga_y_q, vga_y_d;
    logic [C_W-1:0]   vga_colour_q, vga_colour_d;
    logic             vga_plot_q, vga_plot_d;

    logic [NREQ-1:0]  pick_winner;
    logic             pick_any;

    logic [PTR_W-1:0] gnt_idx;
    logic [PTR_W-1:0] ptr_adv;
    logic [X_W-1:0]   sel_x;
    logic [Y_W-1:0]   sel_y;
    logic [C_W-1:0]   sel_colour;
    logic             sel_last;
    logic             beat;
    logic             on_screen;

    rr_priority_picker #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_winner),
        .any    (pick_any)
    );

    // Only the granted slot's fields and last flag are ever looked at.
    always_comb begin
        gnt_idx    = '0;
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_last   = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                gnt_idx    = PTR_W'(i);
                sel_x      = req_x[i*X_W +: X_W];
                sel_y      = req_y[i*Y_W +: Y_W];
                sel_colour = req_colour[i*C_W +: C_W];
                sel_last   = req_last[i];
            end
        end
    end

    assign beat      = |(req & gnt_q);
    assign on_screen = (sel_x < X_W'(SCREEN_W)) && (sel_y < Y_W'(SCREEN_H));
    assign ptr_adv   = (gnt_idx == PTR_W'(NREQ - 1)) ? '0 : gnt_idx + PTR_W'(1);

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        gnt_d        = gnt_q;
        stall_d      = stall_q;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (pick_any) begin
                    gnt_d   = pick_winner;
                    stall_d = '0;
                    state_d = StGrant;
                end
            end
            StGrant: begin
                if (beat) begin
                    stall_d = '0;
                    // Off-screen beats are consumed but leave the VGA port untouched.
                    if (on_screen) begin
                        vga_x_d      = sel_x;
                        vga_y_d      = sel_y;
                        vga_colour_d = sel_colour;
                        vga_plot_d   = 1'b1;
                    end
                    if (sel_last) begin
                        gnt_d   = '0;
                        ptr_d   = ptr_adv;
                        state_d = StRelease;
                    end
                end else if (stall_q == CNT_W'(TIMEOUT - 1)) begin
                    gnt_d   = '0;
                    ptr_d   = ptr_adv;
                    stall_d = '0;
                    state_d = StRelease;
                end else begin
                    stall_d = stall_q + CNT_W'(1);
                end
            end
            StRelease: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            gnt_q        <= '0;
            stall_q      <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            gnt_q        <= gnt_d;
            stall_q      <= stall_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
        end
    end

    assign gnt        = gnt_q;
    assign vga_x      = vga_x_q;
    assign vga_y      = vga_y_q;
    assign vga_colour = vga_colour_q;
    assign vga_plot   = vga_plot_q;
    assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_pixel_port_arbiter.sv
// Directed bench for pixel_port_arbiter: drives and samples on the falling clock edge.
module tb_pixel_port_arbiter;

    localparam int unsigned NREQ = 4;

    logic              clock;
    logic              reset;
    logic [NREQ-1:0]   req;
    logic [NREQ*9-1:0] req_x;
    logic [NREQ*8-1:0] req_y;
    logic [NREQ*3-1:0] req_colour;
    logic [NREQ-1:0]   req_last;
    logic [NREQ-1:0]   gnt;
    logic [8:0]        vga_x;
    logic [7:0]        vga_y;
    logic [2:0]        vga_colour;
    logic              vga_plot;
    logic              busy;

    int n_tests;
    int n_fail;

    pixel_port_arbiter #(
        .NREQ    (NREQ),
        .TIMEOUT (255)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_last   (req_last),
        .gnt        (gnt),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_slot(input int s, input int x, input int y, input int c, input logic last);
        req_x[s*9 +: 9]      = 9'(x);
        req_y[s*8 +: 8]      = 8'(y);
        req_colour[s*3 +: 3] = 3'(c);
        req_last[s]          = last;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        req = '0;
        req_last = '0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    int          cnt [NREQ];
    int          grants;
    int          plots;
    int          zeros;
    int          stalls;
    int          k;
    logic        done;
    logic        finishing;
    logic [NREQ-1:0] prev_gnt;
    logic [NREQ-1:0] exp_gnt;

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        reset      = 1'b1;
        req        = '0;
        req_x      = '0;
        req_y      = '0;
        req_colour = '0;
        req_last   = '0;
        @(negedge clock);
        @(negedge clock);
        check_eq("rst_gnt", 32'(gnt), 0);
        check_eq("rst_plot", 32'(vga_plot), 0);
        check_eq("rst_busy", 32'(busy), 0);
        check_eq("rst_x", 32'(vga_x), 0);
        reset = 1'b0;

        // Single-pixel burst from slot 0.
        @(negedge clock);
        set_slot(0, 120, 40, 7, 1'b1);
        req = 4'b0001;
        @(negedge clock);
        check_eq("t1_gnt", 32'(gnt), 1);
        check_eq("t1_plot_early", 32'(vga_plot), 0);
        check_eq("t1_busy", 32'(busy), 1);
        @(negedge clock);
        req = '0;
        req_last = '0;
        check_eq("t2_plot", 32'(vga_plot), 1);
        check_eq("t2_x", 32'(vga_x), 120);
        check_eq("t2_y", 32'(vga_y), 40);
        check_eq("t2_colour", 32'(vga_colour), 7);
        check_eq("t2_gnt", 32'(gnt), 0);
        @(negedge clock);
        check_eq("t3_gnt", 32'(gnt), 0);
        check_eq("t3_plot", 32'(vga_plot), 0);
        @(negedge clock);
        check_eq("t4_busy", 32'(busy), 0);

        // Four requesters held: 20-pixel bursts served 0,1,2,3,0.
        do_reset();
        for (int s = 0; s < NREQ; s++) begin
            cnt[s] = 0;
            set_slot(s, 10 + s, 20 + s, s, 1'b0);
        end
        req = 4'b1111;
        grants = 0; plots = 0; zeros = 0; prev_gnt = '0;
        done = 1'b0; finishing = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clock);
            req_last = '0;
            if (vga_plot) plots++;
            check_eq("rr_onehot", 32'($onehot0(gnt)), 1);
            if (gnt != 0 && prev_gnt == 0) begin
                if (grants > 0) begin
                    check_eq("rr_plots", 32'(plots), 20);
                    check_eq("rr_bubble", 32'(zeros >= 1), 1);
                end
                exp_gnt = 4'b0001 << (grants % 4);
                check_eq("rr_order", 32'(gnt), 32'(exp_gnt));
                grants++;
                plots = 0;
                zeros = 0;
            end
            if (gnt == 0) begin
                zeros++;
                if (finishing) begin
                    req = '0;
                    done = 1'b1;
                end
            end else begin
                k = 0;
                for (int s = 0; s < NREQ; s++) if (gnt[s]) k = s;
                if (cnt[k] == 19) req_last = gnt;
                cnt[k]++;
                if (cnt[k] == 20) begin
                    cnt[k] = 0;
                    if (grants == 5) finishing = 1'b1;
                end
            end
            prev_gnt = gnt;
        end
        check_eq("rr_done", 32'(done), 1);
        check_eq("rr_grants", 32'(grants), 5);
        @(negedge clock);
        if (vga_plot) plots++;
        check_eq("rr_last_plots", 32'(plots), 20);

        // Slot 2 stalls for 10 cycles mid-burst, then finishes.
        do_reset();
        set_slot(2, 50, 60, 2, 1'b0);
        req = 4'b0100;
        @(negedge clock);
        check_eq("st_gnt", 32'(gnt), 4);
        @(negedge clock);
        check_eq("st_plot1", 32'(vga_plot), 1);
        req = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check_eq("st_stall_plot", 32'(vga_plot), 0);
            check_eq("st_stall_gnt", 32'(gnt), 4);
        end
        set_slot(2, 51, 61, 5, 1'b1);
        req = 4'b0100;
        @(negedge clock);
        req = '0;
        req_last = '0;
        check_eq("st_plot2", 32'(vga_plot), 1);
        check_eq("st_x2", 32'(vga_x), 51);
        check_eq("st_colour2", 32'(vga_colour), 5);
        check_eq("st_gnt_done", 32'(gnt), 0);

        // Slot 1 never sends: grant revoked after 255 stall cycles, pointer moves to 2.
        do_reset();
        set_slot(0, 1, 1, 1, 1'b0);
        set_slot(1, 2, 2, 2, 1'b0);
        set_slot(2, 3, 3, 3, 1'b0);
        req = 4'b0010;
        @(negedge clock);
        check_eq("to_gnt", 32'(gnt), 2);
        req = 4'b0101;
        stalls = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clock);
            stalls++;
            if (gnt != 4'b0010) break;
        end
        check_eq("to_stalls", 32'(stalls), 255);
        check_eq("to_revoked", 32'(gnt), 0);
        @(negedge clock);
        check_eq("to_idle_gnt", 32'(gnt), 0);
        @(negedge clock);
        check_eq("to_next_gnt", 32'(gnt), 4);
        req = '0;
        do_reset();

        // Off-screen beat is swallowed; the following on-screen beat plots.
        set_slot(0, 320, 10, 6, 1'b0);
        req = 4'b0001;
        @(negedge clock);
        check_eq("os_gnt", 32'(gnt), 1);
        @(negedge clock);
        check_eq("os_plot", 32'(vga_plot), 0);
        check_eq("os_x_hold", 32'(vga_x), 0);
        set_slot(0, 199, 10, 3, 1'b1);
        @(negedge clock);
        req = '0;
        req_last = '0;
        check_eq("os_plot2", 32'(vga_plot), 1);
        check_eq("os_x2", 32'(vga_x), 199);
        check_eq("os_y2", 32'(vga_y), 10);
        check_eq("os_colour2", 32'(vga_colour), 3);

        // Reset in the middle of a slot 3 burst, then a fresh arbitration.
        do_reset();
        set_slot(3, 77, 88, 4, 1'b0);
        req = 4'b1000;
        @(negedge clock);
        check_eq("mr_gnt", 32'(gnt), 8);
        @(negedge clock);
        check_eq("mr_plot", 32'(vga_plot), 1);
        reset = 1'b1;
        #1;
        check_eq("mr_rst_gnt", 32'(gnt), 0);
        check_eq("mr_rst_plot", 32'(vga_plot), 0);
        check_eq("mr_rst_x", 32'(vga_x), 0);
        check_eq("mr_rst_busy", 32'(busy), 0);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check_eq("mr_regnt", 32'(gnt), 8);
        check_eq("mr_plot_early", 32'(vga_plot), 0);
        @(negedge clock);
        check_eq("mr_plot_again", 32'(vga_plot), 1);
        check_eq("mr_x_again", 32'(vga_x), 77);
        req = '0;
        @(negedge clock);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
